biu_prefetch_queue: RTL
=======================

Name: biu_prefetch_queue

Overview:
- Instruction prefetch queue between the BIU bus-cycle logic and the execution unit (EU).
- Issues code-fetch requests at physical address CS:fetch_ip and stores the returned bytes in a circular FIFO.
- Hands bytes to the EU through a valid/pop interface.
- On a control transfer (flush), empties the queue and restarts fetching at a new IP.

Parameters:
- DEPTH, 6, queue capacity in bytes (2..15)
- FETCH_THRESH, 2, minimum free slots required to launch a fetch (1..DEPTH)
- CW, $clog2(DEPTH+1), width of q_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cs_in  in  16  current code segment value
- flush  in  1  one-cycle pulse: discard queue, restart at flush_ip
- flush_ip  in  16  new fetch IP, sampled when flush=1
- fetch_req  out  1  code-fetch request to the bus-cycle logic
- fetch_addr  out  20  physical fetch address, stable while fetch_req=1
- fetch_ack  in  1  one-cycle pulse: fetch_data valid, request complete
- fetch_data  in  8  byte returned by memory
- q_valid  out  1  queue non-empty
- q_data  out  8  byte at queue head
- q_pop  in  1  EU consumes the head byte
- q_count  out  CW  bytes currently held
- fetch_ip  out  16  IP of the next byte to be fetched

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, fetch_req=0, fetch_addr=0, fetch_ip=0, q_count=0, q_valid=0, q_data=0.
  - Head/tail pointers 0; storage cleared to 0.
- Free slots: free = DEPTH − q_count.
- FSM states: IDLE, FETCH, DROP.
  - IDLE: if free>=FETCH_THRESH, go to FETCH at the next edge. Capture fetch_addr = ({cs_in,4'b0} + {4'b0,fetch_ip}) mod 2^20.
  - FETCH: fetch_req=1; fetch_addr is held.
    - On fetch_ack: write fetch_data at tail, tail++, q_count++, fetch_ip = fetch_ip+1 mod 2^16 (0xFFFF→0x0000).
    - After the ack, if the post-update free (including a same-cycle pop) is >= FETCH_THRESH, stay in FETCH and recapture fetch_addr from the new fetch_ip. This gives back-to-back fetches with no bubble.
    - Otherwise go to IDLE.
  - DROP: fetch_req=1 with the old fetch_addr held. On fetch_ack the byte is discarded, then go to IDLE. A further flush while in DROP only updates fetch_ip and stays in DROP.
- Request rule: once fetch_req rises it stays high until fetch_ack. It is never withdrawn.
- fetch_ack outside FETCH/DROP is ignored.
- Room guarantee: a launched fetch always has a free slot, because only pops occur while a request is pending.
- Pop/output:
  - q_valid = (q_count!=0); q_data = storage[head], combinational from registers.
  - q_pop with q_valid=1: head++, q_count−− at the edge.
  - q_pop with q_valid=0: ignored.
  - Pointers wrap modulo DEPTH.
- Simultaneous pop + ack (no flush): both take effect; q_count is unchanged. This includes the full-to-full case.
- Flush (highest priority), at the edge where flush=1:
  - q_count=0, head=tail=0, fetch_ip=flush_ip.
  - Any same-cycle q_pop and same-cycle ack byte are discarded.
  - State transitions:
    - From FETCH without a same-cycle ack: go to DROP.
    - From FETCH with a same-cycle ack: go to IDLE.
    - From IDLE: stay in IDLE.
  - In every case, re-fetch from the new IP begins via IDLE on a later cycle.
- Latency:
  - First fetch_req rises 1 cycle after the first edge with rst=0 and empty queue.
  - A byte acked at edge N is visible on q_valid/q_data after edge N.
- cs_in changes take effect only at the next fetch_addr capture.

Test Plan:
- Reset, then cs_in=0x1234, pulse flush with flush_ip=0x00A0 → fetch_req=1 with fetch_addr=0x123E0; ack 0x90 → q_valid=1, q_data=0x90, q_count=1, fetch_ip=0x00A1.
- Ack bytes 0x11..0x66 back-to-back with no pops → fetch_addr steps 0x123E0..0x123E4. After the 5th ack q_count=5 and free=1<2, so fetch_req drops; the 6th byte is never requested. Pop 2 bytes → q_data 0x11 then 0x22, q_count=3, fetch_req re-rises with fetch_addr=0x123E5.
- cs_in=0xFFFF, flush_ip=0xFFFF → fetch_addr=0x0FFEF; after ack fetch_ip=0x0000 and next fetch_addr=0xFFFF0.
- Flush with flush_ip=0x0200 while fetch_req=1 and no ack → q_count=0, fetch_addr holds the old value. The ack byte 0xEE is discarded (q_valid stays 0), then a new request goes out at cs_in*16+0x200.
- DEPTH=6, FETCH_THRESH=1, q_count=5, pop and ack on the same cycle → q_count stays 5, head advances, new byte is at the tail; pop with q_count=0 → no change, q_count stays 0.
- Assert rst mid-FETCH → fetch_req=0, q_count=0, fetch_ip=0 immediately (asynchronous, no clock edge needed).

Source files
------------

// File: rtl/biu_prefetch_queue.sv
// biu_prefetch_queue: code prefetch FIFO between the BIU bus-cycle logic and the EU.
// Launches byte fetches at CS:fetch_ip while enough slots are free, hands bytes to
// the EU through valid/pop, and on a flush empties the queue and restarts at a new IP.
// A fetch that is in flight when a flush arrives is completed and its byte discarded.
module biu_prefetch_queue #(
  parameter int unsigned DEPTH        = 6,
  parameter int unsigned FETCH_THRESH = 2,
  parameter int unsigned CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   cs_in,
  input  logic          flush,
  input  logic [15:0]   flush_ip,
  output logic          fetch_req,
  output logic [19:0]   fetch_addr,
  input  logic          fetch_ack,
  input  logic [7:0]    fetch_data,
  output logic          q_valid,
  output logic [7:0]    q_data,
  input  logic          q_pop,
  output logic [CW-1:0] q_count,
  output logic [15:0]   fetch_ip
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW = CW + 1;
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  localparam logic [FW-1:0] THRESH_F = FW'(FETCH_THRESH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [15:0]   r_fetch_ip;
  logic [19:0]   r_fetch_addr;
  logic          r_fetch_req;

  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [15:0]   w_ip_nxt;
  logic [19:0]   w_addr_nxt;
  logic          w_wr_en;

  logic          w_pop_ok;
  logic [FW-1:0] w_free_now;
  logic [FW-1:0] w_count_ack;
  logic [FW-1:0] w_free_post;
  logic [15:0]   w_ip_inc;
  logic [19:0]   w_addr_cur;
  logic [19:0]   w_addr_inc;

  // Circular pointer advance, wrapping at DEPTH
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Free-slot arithmetic and physical address formation (20-bit wrap)
  assign w_pop_ok    = q_pop && (r_count != '0);
  assign w_free_now  = DEPTH_F - {1'b0, r_count};
  assign w_count_ack = {1'b0, r_count} + FW'(1) - FW'(w_pop_ok);
  assign w_free_post = DEPTH_F - w_count_ack;
  assign w_ip_inc    = r_fetch_ip + 16'd1;
  assign w_addr_cur  = {cs_in, 4'h0} + {4'h0, r_fetch_ip};
  assign w_addr_inc  = {cs_in, 4'h0} + {4'h0, w_ip_inc};

  // Next-state, queue bookkeeping and fetch sequencing; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_ip_nxt    = r_fetch_ip;
    w_addr_nxt  = r_fetch_addr;
    w_wr_en     = 1'b0;

    if (flush) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
      w_ip_nxt    = flush_ip;
      case (r_state)
        ST_FETCH: w_state_nxt = fetch_ack ? ST_IDLE : ST_DROP;
        ST_DROP:  w_state_nxt = fetch_ack ? ST_IDLE : ST_DROP;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else begin
      if (w_pop_ok) begin
        w_head_nxt = ptr_inc(r_head);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_free_now >= THRESH_F) begin
            w_state_nxt = ST_FETCH;
            w_addr_nxt  = w_addr_cur;
          end
        end
        ST_FETCH: begin
          if (fetch_ack) begin
            w_wr_en    = 1'b1;
            w_tail_nxt = ptr_inc(r_tail);
            w_ip_nxt   = w_ip_inc;
            if (w_free_post >= THRESH_F) begin
              w_addr_nxt = w_addr_inc;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (fetch_ack) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      w_count_nxt = r_count + CW'(w_wr_en) - CW'(w_pop_ok);
    end
  end

  // State, pointers, counters and registered request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_fetch_ip   <= '0;
      r_fetch_addr <= '0;
      r_fetch_req  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
      r_fetch_ip   <= w_ip_nxt;
      r_fetch_addr <= w_addr_nxt;
      r_fetch_req  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Byte storage; only accepted fetch data is written, at the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[PW'(i)] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_tail] <= fetch_data;
    end
  end

  assign fetch_req  = r_fetch_req;
  assign fetch_addr = r_fetch_addr;
  assign fetch_ip   = r_fetch_ip;
  assign q_count    = r_count;
  assign q_valid    = (r_count != '0);
  assign q_data     = r_mem[r_head];

endmodule
